// File: rtl/rf_write_sequencer_pkg.sv
// Shared definitions for the register-file write sequencer: sizes, PC index
// and the queued write-entry format.
package rf_write_sequencer_pkg;

  localparam int DEPTH    = 4;
  localparam int DW       = 32;
  localparam int AW       = 4;
  localparam int NUM_REGS = 16;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [AW-1:0] REG_PC = AW'(15);

  typedef struct packed {
    logic [AW-1:0] rg;
    logic [DW-1:0] data;
  } wb_entry_t;

  function automatic logic is_pc(input logic [AW-1:0] rg);
    return rg == REG_PC;
  endfunction

endpackage

// File: rtl/rf_write_sequencer_if.sv
// Result bus into the write sequencer plus its register-file, PC and
// hazard-flag outputs. master = producer/decode side, slave = sequencer.
interface rf_write_sequencer_if;
  import rf_write_sequencer_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic          p_en;
  logic [AW-1:0] p_reg;
  logic [DW-1:0] p_data;
  logic          s_en;
  logic [AW-1:0] s_reg;
  logic [DW-1:0] s_data;

  logic          le;
  logic [AW-1:0] rw;
  logic [DW-1:0] pw;
  logic          pc_load;
  logic [DW-1:0] pc_value;

  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [AW-1:0] rd;
  logic          pend_a;
  logic          pend_b;
  logic          pend_d;
  logic          empty;

  modport master (
    output in_valid, p_en, p_reg, p_data, s_en, s_reg, s_data, ra, rb, rd,
    input  in_ready, le, rw, pw, pc_load, pc_value, pend_a, pend_b, pend_d, empty
  );

  modport slave (
    input  in_valid, p_en, p_reg, p_data, s_en, s_reg, s_data, ra, rb, rd,
    output in_ready, le, rw, pw, pc_load, pc_value, pend_a, pend_b, pend_d, empty
  );

endinterface

// File: rtl/rf_write_sequencer_wb_fifo.sv
// Circular write-back queue: up to two pushes (push0 lands first) and one pop
// per cycle. Per-entry valid bits are exposed for hazard comparison.
module wb_fifo
  import rf_write_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push0,
  input  wb_entry_t        push0_entry,
  input  logic             push1,
  input  wb_entry_t        push1_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             head_valid,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] push1_idx;
  logic [CNT_W-1:0] n_push;
  logic             do_pop;

  // push1 takes the next free slot after push0 when both are present
  assign push1_idx  = push0 ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign n_push     = CNT_W'(push0) + CNT_W'(push1);
  assign head       = entries[rd_ptr];
  assign head_valid = valid[rd_ptr];
  assign do_pop     = pop & head_valid;

  // queue storage, pointers and occupancy; pointers wrap by width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (push0) begin
        entries[wr_ptr] <= push0_entry;
        valid[wr_ptr]   <= 1'b1;
      end
      if (push1) begin
        entries[push1_idx] <= push1_entry;
        valid[push1_idx]   <= 1'b1;
      end
      wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
      count  <= count + n_push - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/rf_write_sequencer.sv
// Write-side driver for the 16x32 register file. Queues up to two results per
// transaction, retires one per clock, redirects R15 writes to a PC load and
// flags read ports whose register still has a write in flight.
module rf_write_sequencer
  import rf_write_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  rf_write_sequencer_if.slave  bus
);

  wb_entry_t        head;
  logic             head_valid;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             pend_a_c;
  logic             pend_b_c;
  logic             pend_d_c;

  // ready only when two slots are free, so a dual transaction always fits
  assign bus.in_ready = count <= CNT_W'(DEPTH - 2);
  assign accept       = bus.in_valid & bus.in_ready;

  // secondary goes in first so a same-register primary wins
  wb_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push0       (accept & bus.s_en),
    .push0_entry ('{rg: bus.s_reg, data: bus.s_data}),
    .push1       (accept & bus.p_en),
    .push1_entry ('{rg: bus.p_reg, data: bus.p_data}),
    .pop         (head_valid),
    .head        (head),
    .head_valid  (head_valid),
    .entries     (entries),
    .valid       (valid),
    .count       (count)
  );

  assign bus.le       = head_valid & ~is_pc(head.rg);
  assign bus.rw       = head.rg;
  assign bus.pw       = head.data;
  assign bus.pc_load  = head_valid & is_pc(head.rg);
  assign bus.pc_value = head.data;
  assign bus.empty    = count == '0;

  // hazard flags: any live entry, including the head retiring now
  always_comb begin
    pend_a_c = 1'b0;
    pend_b_c = 1'b0;
    pend_d_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && entries[i].rg == bus.ra) pend_a_c = 1'b1;
      if (valid[i] && entries[i].rg == bus.rb) pend_b_c = 1'b1;
      if (valid[i] && entries[i].rg == bus.rd) pend_d_c = 1'b1;
    end
  end

  assign bus.pend_a = pend_a_c;
  assign bus.pend_b = pend_b_c;
  assign bus.pend_d = pend_d_c;

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Directed bench for rf_write_sequencer with a behavioural register file.
module tb_rf_write_sequencer;
  import rf_write_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [DW-1:0] rf_model [NUM_REGS];

  rf_write_sequencer_if bus ();

  rf_write_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file as seen by the rest of the core
  always @(posedge clk) begin
    if (bus.le) rf_model[bus.rw] <= bus.pw;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.in_valid = 1'b0;
    bus.p_en     = 1'b0;
    bus.s_en     = 1'b0;
  endtask

  task automatic offer(input logic pe, input logic [AW-1:0] pr, input logic [DW-1:0] pd,
                       input logic se, input logic [AW-1:0] sr, input logic [DW-1:0] sd);
    bus.in_valid = 1'b1;
    bus.p_en     = pe;
    bus.p_reg    = pr;
    bus.p_data   = pd;
    bus.s_en     = se;
    bus.s_reg    = sr;
    bus.s_data   = sd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < NUM_REGS; i++) rf_model[i] = '0;
    rst_n = 1'b0;
    idle_bus();
    bus.p_reg = '0; bus.p_data = '0; bus.s_reg = '0; bus.s_data = '0;
    bus.ra = 4'd3; bus.rb = 4'd9; bus.rd = 4'd9;

    #2;
    chk("rst_le", bus.le, 1'b0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_pc_load", bus.pc_load, 1'b0);
    chk("rst_pend_a", bus.pend_a, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single primary write to R3
    offer(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0);
    tick();
    idle_bus();
    chk("single_le", bus.le, 1'b1);
    chk("single_rw", bus.rw, 32'd3);
    chk("single_pw", bus.pw, 32'hDEAD_BEEF);
    chk("single_pend_a", bus.pend_a, 1'b1);
    chk("single_pend_b", bus.pend_b, 1'b0);
    chk("single_empty", bus.empty, 1'b0);
    tick();
    chk("single_r3", rf_model[3], 32'hDEAD_BEEF);
    chk("single_le_off", bus.le, 1'b0);
    chk("single_drained", bus.empty, 1'b1);
    chk("single_pend_clr", bus.pend_a, 1'b0);

    // dual write: secondary R5 then primary R2
    offer(1'b1, 4'd2, 32'h7, 1'b1, 4'd5, 32'h100);
    tick();
    idle_bus();
    chk("dual_rw0", bus.rw, 32'd5);
    chk("dual_pw0", bus.pw, 32'h100);
    chk("dual_ready", bus.in_ready, 1'b1);
    tick();
    chk("dual_rw1", bus.rw, 32'd2);
    chk("dual_pw1", bus.pw, 32'h7);
    chk("dual_r5", rf_model[5], 32'h100);
    tick();
    chk("dual_r2", rf_model[2], 32'h7);
    chk("dual_empty", bus.empty, 1'b1);

    // same destination: primary value must be final
    offer(1'b1, 4'd4, 32'h2, 1'b1, 4'd4, 32'h1);
    tick();
    idle_bus();
    chk("same_pw0", bus.pw, 32'h1);
    tick(); tick();
    chk("same_r4", rf_model[4], 32'h2);

    // empty transaction is accepted and queues nothing
    offer(1'b0, 4'd6, 32'h55, 1'b0, 4'd6, 32'h66);
    tick();
    idle_bus();
    chk("nop_empty", bus.empty, 1'b1);
    chk("nop_le", bus.le, 1'b0);

    // PC redirect
    offer(1'b1, 4'd15, 32'h40, 1'b0, 4'd0, 32'h0);
    tick();
    idle_bus();
    chk("pc_le", bus.le, 1'b0);
    chk("pc_load", bus.pc_load, 1'b1);
    chk("pc_value", bus.pc_value, 32'h40);
    tick();
    chk("pc_load_off", bus.pc_load, 1'b0);
    chk("pc_not_in_rf", rf_model[15], 32'h0);

    // backpressure: dual transaction offered every cycle
    bus.ra = 4'd5; bus.rb = 4'd6; bus.rd = 4'd9;
    offer(1'b1, 4'd6, 32'hA6, 1'b1, 4'd5, 32'hA5);
    tick();
    chk("bp_ready1", bus.in_ready, 1'b1);
    chk("bp_rw1", bus.rw, 32'd5);
    chk("bp_pend_a1", bus.pend_a, 1'b1);
    tick();
    chk("bp_ready2", bus.in_ready, 1'b0);
    chk("bp_rw2", bus.rw, 32'd6);
    chk("bp_pend_a2", bus.pend_a, 1'b1);
    chk("bp_pend_b2", bus.pend_b, 1'b1);
    chk("bp_pend_d2", bus.pend_d, 1'b0);
    tick();
    idle_bus();
    chk("bp_ready3", bus.in_ready, 1'b1);
    chk("bp_rw3", bus.rw, 32'd5);
    tick();
    chk("bp_rw4", bus.rw, 32'd6);
    chk("bp_pend_a4", bus.pend_a, 1'b0);
    tick();
    chk("bp_empty", bus.empty, 1'b1);
    chk("bp_r6", rf_model[6], 32'hA6);

    // reset with three entries queued: nothing may reach the file
    bus.ra = 4'd8;
    offer(1'b1, 4'd8, 32'hB8, 1'b1, 4'd7, 32'hB7);
    tick();
    offer(1'b1, 4'd8, 32'hC8, 1'b1, 4'd7, 32'hC7);
    tick();
    idle_bus();
    chk("mid_ready", bus.in_ready, 1'b0);
    chk("mid_pend_a", bus.pend_a, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_le", bus.le, 1'b0);
    chk("mid_rst_empty", bus.empty, 1'b1);
    chk("mid_rst_pend", bus.pend_a, 1'b0);
    chk("mid_rst_ready", bus.in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("mid_r7", rf_model[7], 32'hB7);
    chk("mid_r8", rf_model[8], 32'h0);
    chk("mid_le_after", bus.le, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
